imem_loader: RTL and testbench
==============================

# imem_loader

Boot-time instruction-memory writer for the single-cycle MIPS core. It accepts a byte stream over a valid/ready handshake and assembles big-endian 32-bit instruction words. Each word is written sequentially into instruction memory starting at word address 0. The core is held in reset until a complete program has been written. It produces the opcode fields that the core's control decode later consumes, and can optionally reject opcodes the core does not decode.

## Interface
- ADDR_W, 6, instruction-memory word-address width; capacity 2^ADDR_W words
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  synchronous active-low reset
- start  in  1  single-cycle pulse; begins a load (ignored while busy)
- byte_valid  in  1  byte_data valid
- byte_data  in  8  stream byte; first byte of a word is bits 31:24
- byte_last  in  1  qualifies the final byte of the program; sampled with byte_valid&byte_ready
- byte_ready  out  1  loader accepts a byte this cycle
- imem_we  out  1  instruction-memory write enable, one cycle per word
- imem_addr  out  ADDR_W  word address of the write
- imem_wdata  out  32  assembled instruction word
- cpu_rst_n  out  1  core reset; 0 unless in DONE
- busy  out  1  high in RECV and WRITE
- done  out  1  high in DONE
- err  out  1  high in ERROR
- word_count  out  ADDR_W+1  words written in the current load

## Operation
- States: IDLE, RECV, WRITE, DONE, ERROR. Reset state is IDLE.
- IDLE: byte_ready=0. A start pulse clears byte_idx, word_ptr and word_count, then moves to RECV.
- RECV: byte_ready=1. On each accepted byte:
  - shift[31:0] ← {shift[23:0], byte_data}; byte_idx increments (2-bit, wraps).
  - Accepted byte with byte_idx==3 → WRITE; last_seen ← byte_last.
  - Accepted byte with byte_last=1 and byte_idx≠3 → ERROR; the partial word is discarded.
- WRITE: byte_ready=0, imem_we=1, imem_addr=word_ptr, imem_wdata=shift. word_ptr and word_count increment on exit. Next state:
  - last_seen=1 → DONE.
  - Otherwise, word_ptr==2^ADDR_W−1 → ERROR (memory full before the last byte).
  - Otherwise → RECV.
- DONE: cpu_rst_n=1, done=1. start → RECV with counters cleared and cpu_rst_n dropping to 0.
- ERROR: err=1, cpu_rst_n=0. Only start exits, to RECV with counters cleared. Memory already written is not erased.
- start in RECV or WRITE is ignored.
- rst_n low in any state returns the block to IDLE and discards any partial word. Writes already performed stay in memory.

## Timing
- Reset values: byte_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, cpu_rst_n=0, busy=0, done=0, err=0, word_count=0.
- All outputs are decoded from registered state or driven directly from registers; there are no combinational paths from inputs to outputs.
- The 4th byte of a word is accepted at edge k. WRITE occupies cycle k..k+1 with imem_we=1, and the memory captures the word at edge k+1.
- byte_ready is low during WRITE. Minimum throughput is 5 cycles per word when byte_valid is held high.
- After the final word's WRITE cycle, DONE is entered and cpu_rst_n=1 from the next cycle. Latency from the last byte accepted to cpu_rst_n high is 2 edges.
- Bubbles on byte_valid stall RECV indefinitely; there is no timeout.
- byte_data and byte_last are ignored when byte_valid=0 or byte_ready=0.

## Configuration
- LOADER_OPCODE_CHECK_EN defined:
  - In WRITE, shift[31:26] is checked against {0x00, 0x08, 0x04, 0x02, 0x23, 0x2B}.
  - A mismatching word forces imem_we=0 and moves to ERROR; word_count is not incremented.
- LOADER_OPCODE_CHECK_EN undefined: every assembled word is written and no opcode check logic exists.

## Test plan
- Reset: rst_n=0 for 2 cycles, then 1 → byte_ready=0, imem_we=0, cpu_rst_n=0, done=0, err=0, word_count=0.
- Two-word load: start; bytes 20 08 00 05 8C 09 00 04 with byte_last on the 8th byte → write addr 0 = 0x20080005, then addr 1 = 0x8C090004; done=1, word_count=2, cpu_rst_n=1 two edges after the last byte.
- Misaligned last: start; bytes 00 00 20 with byte_last on the 3rd byte → err=1, no imem_we pulse, cpu_rst_n=0; a following start re-enters RECV with err=0.
- Overflow (ADDR_W=2): start; 16 bytes with no byte_last → 4 writes at addr 0..3, then err=1, word_count=4.
- Opcode check: with LOADER_OPCODE_CHECK_EN, word FC 00 00 00 → no write, err=1. Without the macro → written at addr 0 and the load continues.
- Stall and abort: gaps of 3 idle cycles between bytes give correct words. rst_n pulsed low after 2 bytes of a word → IDLE, no write, cpu_rst_n=0.

Source files
------------

// File: rtl/imem_loader.sv
// Boot-time instruction-memory loader: assembles big-endian words from a byte stream.
// Optional opcode screening is enabled with the LOADER_OPCODE_CHECK_EN macro.
module imem_loader #(
   parameter int ADDR_W = 6
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              byte_valid,
   input  logic [7:0]        byte_data,
   input  logic              byte_last,
   output logic              byte_ready,
   output logic              imem_we,
   output logic [ADDR_W-1:0] imem_addr,
   output logic [31:0]       imem_wdata,
   output logic              cpu_rst_n,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic [ADDR_W:0]   word_count
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_RECV,
      S_WRITE,
      S_DONE,
      S_ERROR
   } state_t;

   state_t            state;
   state_t            state_nx;
   logic [31:0]       shift;
   logic [1:0]        byte_idx;
   logic [ADDR_W-1:0] word_ptr;
   logic [ADDR_W:0]   count;
   logic              last_seen;
   logic              accept;
   logic              opcode_ok;
   logic              clear;
   logic              advance;

   assign accept = (state == S_RECV) && byte_valid;

`ifdef LOADER_OPCODE_CHECK_EN
   // Only opcodes the core's control decode understands may be written.
   always_comb begin
      opcode_ok = 1'b0;
      case (shift[31:26])
         6'h00, 6'h08, 6'h04, 6'h02, 6'h23, 6'h2B: opcode_ok = 1'b1;
         default:                                  opcode_ok = 1'b0;
      endcase
   end
`else
   assign opcode_ok = 1'b1;
`endif

   always_comb begin
      state_nx = state;
      clear    = 1'b0;
      advance  = 1'b0;
      case (state)
         S_IDLE, S_DONE, S_ERROR: begin
            if (start) begin
               state_nx = S_RECV;
               clear    = 1'b1;
            end
         end
         S_RECV: begin
            if (accept) begin
               if (byte_idx == 2'd3) begin
                  state_nx = S_WRITE;
               end else if (byte_last) begin
                  state_nx = S_ERROR;
               end
            end
         end
         S_WRITE: begin
            if (!opcode_ok) begin
               state_nx = S_ERROR;
            end else begin
               advance = 1'b1;
               // A final word landing in the top slot still completes the load.
               if (last_seen) begin
                  state_nx = S_DONE;
               end else if (word_ptr == {ADDR_W{1'b1}}) begin
                  state_nx = S_ERROR;
               end else begin
                  state_nx = S_RECV;
               end
            end
         end
         default: state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         shift     <= '0;
         byte_idx  <= '0;
         word_ptr  <= '0;
         count     <= '0;
         last_seen <= 1'b0;
      end else begin
         state <= state_nx;
         if (clear) begin
            byte_idx  <= '0;
            word_ptr  <= '0;
            count     <= '0;
            last_seen <= 1'b0;
         end
         if (accept) begin
            shift    <= {shift[23:0], byte_data};
            byte_idx <= byte_idx + 2'd1;
            if (byte_idx == 2'd3) begin
               last_seen <= byte_last;
            end
         end
         if (advance) begin
            word_ptr <= word_ptr + 1'b1;
            count    <= count + 1'b1;
         end
      end
   end

   assign byte_ready = (state == S_RECV);
   assign imem_we    = (state == S_WRITE) && opcode_ok;
   assign imem_addr  = word_ptr;
   assign imem_wdata = shift;
   assign cpu_rst_n  = (state == S_DONE);
   assign busy       = (state == S_RECV) || (state == S_WRITE);
   assign done       = (state == S_DONE);
   assign err        = (state == S_ERROR);
   assign word_count = count;

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: a byte-level load model predicts writes and final status.
module tb_imem_loader;

   localparam int AW  = 2;
   localparam int CAP = 1 << AW;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic          byte_valid = 1'b0;
   logic [7:0]    byte_data = 8'h00;
   logic          byte_last = 1'b0;
   logic          byte_ready;
   logic          imem_we;
   logic [AW-1:0] imem_addr;
   logic [31:0]   imem_wdata;
   logic          cpu_rst_n;
   logic          busy;
   logic          done;
   logic          err;
   logic [AW:0]   word_count;

   imem_loader #(.ADDR_W(AW)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .byte_valid (byte_valid),
      .byte_data  (byte_data),
      .byte_last  (byte_last),
      .byte_ready (byte_ready),
      .imem_we    (imem_we),
      .imem_addr  (imem_addr),
      .imem_wdata (imem_wdata),
      .cpu_rst_n  (cpu_rst_n),
      .busy       (busy),
      .done       (done),
      .err        (err),
      .word_count (word_count)
   );

   always #5 clk = ~clk;

   int            checks = 0;
   int            errors = 0;
   logic [AW+31:0] sb[$];
   logic [7:0]    stim[64];
   int            nbytes;
   int            last_idx;
   int            exp_consumed;
   int            exp_lat;
   int            exp_count;
   logic          exp_err;
   logic          exp_we;
   logic [5:0]    ops[6] = '{6'h00, 6'h08, 6'h04, 6'h02, 6'h23, 6'h2B};

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   function automatic bit op_ok(input logic [31:0] w);
`ifdef LOADER_OPCODE_CHECK_EN
      logic [5:0] op;
      op = w[31:26];
      return op inside {6'h00, 6'h08, 6'h04, 6'h02, 6'h23, 6'h2B};
`else
      return (^w !== 1'bx);
`endif
   endfunction

   // Walks the byte list as the loader should see it and queues every expected write.
   task automatic modelLoad();
      int          cnt;
      logic [31:0] w;
      cnt          = 0;
      exp_consumed = nbytes;
      exp_err      = 1'b1;
      exp_lat      = 2;
      exp_we       = 1'b0;
      exp_count    = 0;
      for (int i = 0; i < nbytes; i++) begin
         if (i == last_idx && (i % 4) != 3) begin
            exp_consumed = i + 1;
            exp_lat      = 1;
            exp_count    = cnt;
            return;
         end
         if ((i % 4) == 3) begin
            w = {stim[i-3], stim[i-2], stim[i-1], stim[i]};
            if (!op_ok(w)) begin
               exp_consumed = i + 1;
               exp_we       = 1'b0;
               exp_count    = cnt;
               return;
            end
            sb.push_back({AW'(cnt), w});
            cnt++;
            if (i == last_idx) begin
               exp_consumed = i + 1;
               exp_err      = 1'b0;
               exp_we       = 1'b1;
               exp_count    = cnt;
               return;
            end
            if (cnt == CAP) begin
               exp_consumed = i + 1;
               exp_we       = 1'b1;
               exp_count    = cnt;
               return;
            end
         end
      end
      exp_count = cnt;
   endtask

   task automatic sendByte(input logic [7:0] d, input logic last, input int gmin, input int gmax);
      int waited;
      waited = 0;
      repeat ($urandom_range(gmax, gmin)) @(negedge clk);
      byte_valid = 1'b1;
      byte_data  = d;
      byte_last  = last;
      while (byte_ready !== 1'b1 && waited < 20) begin
         @(negedge clk);
         waited++;
      end
      if (waited >= 20) begin
         checks++;
         errors++;
         $display("[TB] FAIL ready_timeout actual=0 expected=1");
         byte_valid = 1'b0;
         return;
      end
      @(negedge clk);
      byte_valid = 1'b0;
      byte_data  = 8'($urandom);
      byte_last  = 1'($urandom);
   endtask

   // One complete load from start pulse to final status.
   task automatic applyStimulus(input int gmin, input int gmax, input bit mid_start);
      modelLoad();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      checkOutput("start_busy", 32'(busy), 32'd1);
      checkOutput("start_cpu_rst_n", 32'(cpu_rst_n), 32'd0);
      checkOutput("start_count", 32'(word_count), 32'd0);
      checkOutput("start_err", 32'(err), 32'd0);
      for (int i = 0; i < exp_consumed; i++) begin
         if (mid_start && (i == 2 || i == 4)) begin
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
         end
         sendByte(stim[i], (i == last_idx), gmin, gmax);
      end
      if (exp_lat == 2) begin
         checkOutput("pre_we", 32'(imem_we), 32'(exp_we));
         checkOutput("pre_done", 32'(done), 32'd0);
         checkOutput("pre_err", 32'(err), 32'd0);
         @(negedge clk);
      end
      checkOutput("end_done", 32'(done), 32'(!exp_err));
      checkOutput("end_err", 32'(err), 32'(exp_err));
      checkOutput("end_cpu_rst_n", 32'(cpu_rst_n), 32'(!exp_err));
      checkOutput("end_busy", 32'(busy), 32'd0);
      checkOutput("end_ready", 32'(byte_ready), 32'd0);
      checkOutput("end_count", 32'(word_count), 32'(exp_count));
      @(negedge clk);
      checkOutput("sb_drained", 32'(sb.size()), 32'd0);
      sb.delete();
   endtask

   always @(negedge clk) begin
      logic [AW+31:0] e;
      if (imem_we === 1'b1) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpected_write actual=%0h@%0h expected=none", imem_wdata, imem_addr);
         end else begin
            e = sb.pop_front();
            checkOutput("write_addr", 32'(imem_addr), 32'(e[AW+31:32]));
            checkOutput("write_data", imem_wdata, e[31:0]);
         end
      end
   end

   initial begin
      logic [7:0] two[8];
      logic [7:0] bad[8];
      int         nwords;
      int         mode;

      repeat (2) @(negedge clk);
      checkOutput("rst_ready", 32'(byte_ready), 32'd0);
      checkOutput("rst_we", 32'(imem_we), 32'd0);
      checkOutput("rst_addr", 32'(imem_addr), 32'd0);
      checkOutput("rst_wdata", imem_wdata, 32'd0);
      checkOutput("rst_cpu_rst_n", 32'(cpu_rst_n), 32'd0);
      checkOutput("rst_busy", 32'(busy), 32'd0);
      checkOutput("rst_done", 32'(done), 32'd0);
      checkOutput("rst_err", 32'(err), 32'd0);
      checkOutput("rst_count", 32'(word_count), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      two = '{8'h20, 8'h08, 8'h00, 8'h05, 8'h8C, 8'h09, 8'h00, 8'h04};
      foreach (two[i]) stim[i] = two[i];
      nbytes = 8; last_idx = 7;
      applyStimulus(0, 0, 1'b0);

      stim[0] = 8'h00; stim[1] = 8'h00; stim[2] = 8'h20;
      nbytes = 3; last_idx = 2;
      applyStimulus(0, 0, 1'b0);

      for (int i = 0; i < 16; i++) stim[i] = (i % 4 == 0) ? {ops[i % 6], 2'(i)} : 8'(i * 17);
      nbytes = 16; last_idx = -1;
      applyStimulus(0, 0, 1'b0);

      bad = '{8'hFC, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01};
      foreach (bad[i]) stim[i] = bad[i];
      nbytes = 8; last_idx = 7;
      applyStimulus(0, 0, 1'b0);

      foreach (two[i]) stim[i] = two[i];
      nbytes = 8; last_idx = 7;
      applyStimulus(3, 3, 1'b1);

      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      sendByte(8'h8C, 1'b0, 0, 1);
      sendByte(8'h09, 1'b0, 0, 1);
      rst_n = 1'b0;
      @(negedge clk);
      checkOutput("abort_ready", 32'(byte_ready), 32'd0);
      checkOutput("abort_cpu_rst_n", 32'(cpu_rst_n), 32'd0);
      checkOutput("abort_busy", 32'(busy), 32'd0);
      checkOutput("abort_count", 32'(word_count), 32'd0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      checkOutput("abort_idle_ready", 32'(byte_ready), 32'd0);

      for (int t = 0; t < 25; t++) begin
         mode   = $urandom_range(2, 0);
         nwords = (mode == 2) ? CAP : $urandom_range(CAP + 1, 1);
         for (int i = 0; i < nwords * 4; i++) begin
            if (i % 4 == 0 && $urandom_range(3, 0) != 0) stim[i] = {ops[$urandom_range(5, 0)], 2'($urandom)};
            else stim[i] = 8'($urandom);
         end
         if (mode == 0) last_idx = nwords * 4 - 1;
         else if (mode == 1) last_idx = 4 * $urandom_range(nwords - 1, 0) + $urandom_range(2, 0);
         else last_idx = -1;
         nbytes = (mode == 2) ? CAP * 4 : last_idx + 1;
         applyStimulus(0, 2, 1'($urandom));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
